// File: rtl/inst_arb_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
package inst_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    localparam int unsigned N_REQ_DEFAULT    = 5;
    localparam int unsigned MAX_HOLD_DEFAULT = 16;

endpackage : inst_arb_pkg

// File: rtl/inst_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: the first eligible request at or after ptr, cyclically,
// wins. Bits set in mask are never picked.
module rr_pick
    import inst_arb_pkg::*;
#(
    parameter  int unsigned N_REQ = N_REQ_DEFAULT,
    localparam int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    input  logic [N_REQ-1:0] mask,
    output logic [N_REQ-1:0] pick,
    output logic [IDW-1:0]   pick_id,
    output logic             any
);

    logic [N_REQ-1:0] eligible;
    int unsigned      idx;
    logic [IDW-1:0]   idx_w;

    always_comb begin
        pick     = '0;
        pick_id  = '0;
        any      = 1'b0;
        idx      = 0;
        idx_w    = '0;
        eligible = req & ~mask;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_w = IDW'(idx);
            if (!any && eligible[idx_w]) begin
                any         = 1'b1;
                pick[idx_w] = 1'b1;
                pick_id     = idx_w;
            end
        end
    end

endmodule : rr_pick

// File: rtl/inst_rr_arbiter.sv
// Round-robin arbiter sharing one resource among N_REQ children; grant held until release.
// Optional hold-time watchdog built when ARB_TIMEOUT_EN is defined.
module inst_rr_arbiter
    import inst_arb_pkg::*;
#(
    parameter  int unsigned N_REQ    = N_REQ_DEFAULT,
    parameter  int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
    localparam int unsigned IDW      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDW-1:0]   gnt_id,
    output logic             timeout
);

    if (N_REQ < 2 || MAX_HOLD < 1) begin : g_cfg_check
        $error("inst_rr_arbiter: N_REQ must be >= 2 and MAX_HOLD >= 1");
    end

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             gnt_valid_q;
    logic             timeout_q, timeout_d;

    logic [IDW-1:0]   next_ptr_c;
    logic [IDW-1:0]   pick_ptr_c;
    logic [N_REQ-1:0] pick_mask_c;
    logic [N_REQ-1:0] pick_c;
    logic [IDW-1:0]   pick_id_c;
    logic             pick_any_c;
    logic             normal_rel_c;
    logic             force_c;
    logic             new_grant_c;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req     (req),
        .ptr     (pick_ptr_c),
        .mask    (pick_mask_c),
        .pick    (pick_c),
        .pick_id (pick_id_c),
        .any     (pick_any_c)
    );

    assign next_ptr_c   = (gnt_id_q == IDW'(N_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);
    assign normal_rel_c = done[gnt_id_q] | ~req[gnt_id_q];

    // Picker looks from ptr when idle, and from owner+1 with the owner masked on release.
    always_comb begin
        pick_ptr_c  = ptr_q;
        pick_mask_c = '0;
        if (state_q == OWNED) begin
            pick_ptr_c  = next_ptr_c;
            pick_mask_c = gnt_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        timeout_d   = 1'b0;
        new_grant_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any_c) begin
                    state_d     = OWNED;
                    gnt_d       = pick_c;
                    gnt_id_d    = pick_id_c;
                    new_grant_c = 1'b1;
                end
            end
            OWNED: begin
                if (normal_rel_c || force_c) begin
                    ptr_d     = next_ptr_c;
                    timeout_d = force_c & ~normal_rel_c;
                    if (pick_any_c) begin
                        gnt_d       = pick_c;
                        gnt_id_d    = pick_id_c;
                        new_grant_c = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= |gnt_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HCW = $clog2(MAX_HOLD + 1);

    logic [HCW-1:0] hold_q, hold_d;

    // Counts cycles the current owner has held; restarts on every new grant.
    always_comb begin
        hold_d = '0;
        if (state_d == OWNED && !new_grant_c) begin
            hold_d = hold_q + HCW'(1);
        end
    end

    assign force_c = (state_q == OWNED) && (hold_q == HCW'(MAX_HOLD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign force_c = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;

endmodule : inst_rr_arbiter

// File: tb/tb_inst_rr_arbiter.sv
// Directed + randomized bench for inst_rr_arbiter against an integer-level round-robin model.
module tb_inst_rr_arbiter;

    localparam int unsigned N        = 5;
    localparam int unsigned MAX_HOLD = 16;
    localparam int unsigned IDW      = $clog2(N);
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    // model state: owner index (-1 idle), priority pointer, cycles held, timeout pulse
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    inst_rr_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic bit bit_of(logic [N-1:0] v, int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    function automatic int scan(logic [N-1:0] r, int from, int excl);
        int idx;
        for (int i = 0; i < int'(N); i++) begin
            idx = (from + i) % int'(N);
            if (idx != excl && bit_of(r, idx)) return idx;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(logic [N-1:0] r, logic [N-1:0] d);
        bit norm;
        bit forced;
        m_to = 1'b0;
        if (m_owner < 0) begin
            m_owner = scan(r, m_ptr, -1);
            m_hold  = 0;
        end else begin
            norm   = bit_of(d, m_owner) || !bit_of(r, m_owner);
            forced = TO_EN && (m_hold == int'(MAX_HOLD) - 1);
            if (norm || forced) begin
                m_ptr   = (m_owner + 1) % int'(N);
                m_to    = forced && !norm;
                m_owner = scan(r, m_ptr, m_owner);
                m_hold  = 0;
            end else begin
                m_hold++;
            end
        end
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        logic [N-1:0] e_gnt;
        e_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(m_owner >= 0));
        check({tag, ".gnt_id"},    32'(gnt_id),    (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check({tag, ".timeout"},   32'(timeout),   32'(m_to));
    endtask

    task automatic step(string tag, logic [N-1:0] r, logic [N-1:0] d);
        req  = r;
        done = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        rst  = 1'b1;
        req  = '0;
        done = '0;
        model_reset();
        #1;
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] d;
        int           seq[6];
        int           run;
        int           max_run;
        int           obs_to;
        int           exp_to;

        rst  = 1'b1;
        req  = '0;
        done = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // first grant appears one cycle after the request is sampled
        step("t2_grant", 5'b00100, 5'b00000);
        check("t2_gnt_const", 32'(gnt), 32'h04);

        // asynchronous reset in the middle of a cycle drops the grant immediately
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs("t1_async_rst");
        check("t1_gnt_zero", 32'(gnt), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step("t1_after", 5'b00010, 5'b00000);
        check("t1_gnt_const", 32'(gnt), 32'h02);

        // all requesting, owner releases 2 cycles after each grant
        do_reset("t3_rst");
        step("t3_first", 5'b11111, 5'b00000);
        seq[0] = int'(gnt_id);
        for (int g = 1; g < 6; g++) begin
            step("t3_hold", 5'b11111, 5'b00000);
            step("t3_rel", 5'b11111, N'(1) << gnt_id);
            seq[g] = int'(gnt_id);
        end
        for (int g = 0; g < 6; g++) begin
            check($sformatf("t3_seq%0d", g), 32'(seq[g]), 32'(g % 5));
        end

        // wrap from owner 4 back to 0 without a bubble
        do_reset("t4_rst");
        step("t4_own4", 5'b10000, 5'b00000);
        step("t4_wrap", 5'b10001, 5'b10000);
        check("t4_gnt_const", 32'(gnt), 32'h01);
        step("t4_next", 5'b00011, 5'b00001);
        check("t4_ptr_after_wrap", 32'(gnt_id), 32'd1);

        // done from non-owners is ignored
        do_reset("t6_rst");
        step("t6_own3", 5'b01000, 5'b00000);
        step("t6_noise_a", 5'b01101, 5'b00101);
        check("t6_hold_a", 32'(gnt), 32'h08);
        step("t6_noise_b", 5'b01101, 5'b00001);
        check("t6_hold_b", 32'(gnt), 32'h08);
        step("t6_release", 5'b01101, 5'b01000);
        check("t6_next", 32'(gnt), 32'h01);

        // idle done without request is ignored
        do_reset("idle_done_rst");
        step("idle_done", 5'b00000, 5'b11111);

        // long hold with a single requester
        do_reset("t5_rst");
        run     = 0;
        max_run = 0;
        obs_to  = 0;
        exp_to  = 0;
        for (int c = 0; c < 120; c++) begin
            step("t5", 5'b00010, 5'b00000);
            run = (gnt == 5'b00010) ? run + 1 : 0;
            if (run > max_run) max_run = run;
            obs_to += int'(timeout);
            exp_to += int'(m_to);
        end
        check("t5_max_run", 32'(max_run), TO_EN ? 32'(MAX_HOLD) : 32'd120);
        check("t5_timeouts", 32'(obs_to), 32'(exp_to));

        // randomized traffic against the model
        do_reset("rand_rst");
        r = '0;
        for (int c = 0; c < 600; c++) begin
            r = r ^ (N'($urandom) & N'($urandom));
            d = N'($urandom) & N'($urandom) & N'($urandom);
            if (m_owner >= 0 && ($urandom % 4) == 0) begin
                d = d | (N'(1) << m_owner);
            end
            step("rand", r, d);
            check("rand_onehot", 32'($onehot0(gnt)), 32'd1);
            if (c == 300) begin
                do_reset("rand_midrst");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_inst_rr_arbiter
